// File: rtl/stream_to_ppfifo.sv
// stream_to_ppfifo: packs a valid/ready word stream into ping-pong FIFO buffers.
// Ports: clk, rst_n (async low); upstream i_valid/o_ready/i_data; i_flush;
//        FIFO side i_wr_rdy/o_wr_act/i_wr_size/o_wr_stb/o_wr_data; o_busy.
module stream_to_ppfifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_flush,
   input  logic [1:0]            i_wr_rdy,
   output logic [1:0]            o_wr_act,
   input  logic [23:0]           i_wr_size,
   output logic                  o_wr_stb,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      RELEASE
   } state_t;

   localparam logic [15:0] TMO = 16'(IDLE_TIMEOUT);

   state_t                state_q, state_d;
   logic [1:0]            act_q, act_d;
   logic [23:0]           size_q, size_d;
   logic [23:0]           count_q, count_d;
   logic [15:0]           stall_q, stall_d;
   logic [15:0]           stall_inc;
   logic                  stb_q, stb_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  armed_q, armed_d;
   logic                  accept;

   assign o_ready   = (state_q == ACTIVE) && (count_q < size_q);
   assign accept    = i_valid && o_ready;
   assign stall_inc = (&stall_q) ? stall_q : stall_q + 16'd1;

   assign o_wr_act  = act_q;
   assign o_wr_stb  = stb_q;
   assign o_wr_data = data_q;
   assign o_busy    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      size_d  = size_q;
      count_d = count_q;
      stall_d = stall_q;
      stb_d   = 1'b0;
      data_d  = data_q;
      armed_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            act_d = 2'b00;
            // armed_q keeps the first edge after reset from activating
            if (armed_q && (i_wr_rdy != 2'b00)) begin
               state_d = ACTIVE;
               act_d   = i_wr_rdy[0] ? 2'b01 : 2'b10;
               size_d  = i_wr_size;
               count_d = '0;
               stall_d = '0;
            end
         end
         ACTIVE: begin
            if (accept) begin
               count_d = count_q + 24'd1;
               stall_d = '0;
               stb_d   = 1'b1;
               data_d  = i_data;
               if ((count_d == size_q) || i_flush) begin
                  state_d = RELEASE;
               end
            end else if (count_q != 24'd0) begin
               stall_d = stall_inc;
               if ((stall_inc >= TMO) || i_flush) begin
                  state_d = RELEASE;
               end
            end else if (size_q == 24'd0) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            act_d   = 2'b00;
            state_d = IDLE;
         end
         default: begin
            act_d   = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         act_q   <= 2'b00;
         size_q  <= '0;
         count_q <= '0;
         stall_q <= '0;
         stb_q   <= 1'b0;
         data_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         size_q  <= size_d;
         count_q <= count_d;
         stall_q <= stall_d;
         stb_q   <= stb_d;
         data_q  <= data_d;
         armed_q <= armed_d;
      end
   end

endmodule
